mem_bus_arbiter: RTL and testbench

Shares the core's single memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage). One transaction is outstanding at a time. The winning request's fields are latched at grant, driven to the bus until the bus accepts them, and the bus response is routed back to the owner. Data requests win ties. A streak counter stops back-to-back loads and stores from starving fetch. The block sits between the pipeline's `ireq`/`dreq` ports and the core's bus interface.

---
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and data access.
// One transaction is in flight at a time; data wins ties within a bounded streak.
module mem_bus_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        bus_valid,
  output logic        bus_is_write,
  output logic [63:0] bus_addr,
  output logic [2:0]  bus_size,
  output logic [7:0]  bus_strobe,
  output logic [63:0] bus_data,
  input  logic        bus_ready,
  input  logic [63:0] bus_rdata,
  output logic [1:0]  grant
);

  // State encoding doubles as the grant code seen by the core.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10
  } state_t;

  localparam logic [3:0] MAX_STREAK_C = 4'(MAX_D_STREAK);

  state_t      state_r;
  logic [3:0]  d_streak_r;
  logic [63:0] addr_r;
  logic [2:0]  size_r;
  logic [7:0]  strobe_r;
  logic [63:0] data_r;

  logic        pick_d_s;
  logic        pick_i_s;
  logic        granted_s;

  function automatic logic strobe_is_write(input logic [7:0] strobe);
    return |strobe;
  endfunction

  // Arbitration: data wins ties until it has used up its streak allowance.
  always_comb begin
    pick_d_s = 1'b0;
    pick_i_s = 1'b0;
    if (dreq_valid && ireq_valid) begin
      if (d_streak_r < MAX_STREAK_C) begin
        pick_d_s = 1'b1;
      end else begin
        pick_i_s = 1'b1;
      end
    end else if (dreq_valid) begin
      pick_d_s = 1'b1;
    end else if (ireq_valid) begin
      pick_i_s = 1'b1;
    end else begin
      pick_d_s = 1'b0;
      pick_i_s = 1'b0;
    end
  end

  // Ownership FSM, request latch and data streak counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      d_streak_r <= 4'd0;
      addr_r     <= 64'd0;
      size_r     <= 3'd0;
      strobe_r   <= 8'd0;
      data_r     <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_d_s) begin
            state_r  <= GRANT_D;
            addr_r   <= dreq_addr;
            size_r   <= dreq_size;
            strobe_r <= dreq_strobe;
            data_r   <= dreq_data;
            if (ireq_valid) begin
              d_streak_r <= (d_streak_r >= MAX_STREAK_C) ? MAX_STREAK_C : d_streak_r + 4'd1;
            end else begin
              d_streak_r <= 4'd0;
            end
          end else if (pick_i_s) begin
            state_r    <= GRANT_I;
            addr_r     <= ireq_addr;
            size_r     <= 3'd2;
            strobe_r   <= 8'd0;
            data_r     <= 64'd0;
            d_streak_r <= 4'd0;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT_I, GRANT_D: begin
          if (bus_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Bus side is driven purely from the latch; responses steer to the owner only.
  always_comb begin
    granted_s     = (state_r != IDLE);
    bus_valid     = granted_s;
    bus_addr      = granted_s ? addr_r : 64'd0;
    bus_size      = granted_s ? size_r : 3'd0;
    bus_strobe    = granted_s ? strobe_r : 8'd0;
    bus_data      = granted_s ? data_r : 64'd0;
    bus_is_write  = granted_s ? strobe_is_write(strobe_r) : 1'b0;
    grant         = state_r;
    iresp_data_ok = (state_r == GRANT_I) && bus_ready;
    dresp_data_ok = (state_r == GRANT_D) && bus_ready;
    iresp_data    = iresp_data_ok ? bus_rdata[31:0] : 32'd0;
    dresp_data    = dresp_data_ok ? bus_rdata : 64'd0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int MAXS = 4;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        bus_valid;
  logic        bus_is_write;
  logic [63:0] bus_addr;
  logic [2:0]  bus_size;
  logic [7:0]  bus_strobe;
  logic [63:0] bus_data;
  logic        bus_ready;
  logic [63:0] bus_rdata;
  logic [1:0]  grant;

  int checks = 0;
  int failures = 0;

  mem_bus_arbiter #(.MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .bus_valid(bus_valid), .bus_is_write(bus_is_write), .bus_addr(bus_addr),
    .bus_size(bus_size), .bus_strobe(bus_strobe), .bus_data(bus_data),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .grant(grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        iv;
    logic        dv;
    logic [63:0] iaddr;
    logic [63:0] daddr;
    logic [2:0]  dsize;
    logic [7:0]  dstrobe;
    logic [63:0] ddata;
    logic [63:0] rdata;
    logic [1:0]  e_grant;
    logic [63:0] e_addr;
    logic [2:0]  e_size;
    logic [7:0]  e_strobe;
    logic [63:0] e_data;
    logic        e_write;
    logic        e_iok;
    logic        e_dok;
    logic [31:0] e_irdata;
    logic [63:0] e_drdata;
  } vec_t;

  vec_t vecs[6];

  // Reference model: who owns the bus, what was latched, and how many data
  // grants in a row have been handed out while fetch was waiting.
  int          m_owner;
  int          m_run;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  logic [63:0] m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ireq_valid  = 1'b0;
    ireq_addr   = 64'd0;
    dreq_valid  = 1'b0;
    dreq_addr   = 64'd0;
    dreq_size   = 3'd0;
    dreq_strobe = 8'd0;
    dreq_data   = 64'd0;
    bus_ready   = 1'b0;
    bus_rdata   = 64'd0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_run    = 0;
    m_addr   = 64'd0;
    m_size   = 3'd0;
    m_strobe = 8'd0;
    m_data   = 64'd0;
  endtask

  task automatic model_check();
    logic        own;
    logic        iok;
    logic        dok;
    own = (m_owner != 0);
    iok = (m_owner == 1) && bus_ready;
    dok = (m_owner == 2) && bus_ready;
    chk("rnd_bus_valid", 64'(bus_valid), 64'(own));
    chk("rnd_grant", 64'(grant), (m_owner == 1) ? 64'd1 : (m_owner == 2) ? 64'd2 : 64'd0);
    chk("rnd_addr", bus_addr, own ? m_addr : 64'd0);
    chk("rnd_size", 64'(bus_size), own ? 64'(m_size) : 64'd0);
    chk("rnd_strobe", 64'(bus_strobe), own ? 64'(m_strobe) : 64'd0);
    chk("rnd_wdata", bus_data, own ? m_data : 64'd0);
    chk("rnd_is_write", 64'(bus_is_write), 64'(own && (m_strobe != 8'd0)));
    chk("rnd_iok", 64'(iresp_data_ok), 64'(iok));
    chk("rnd_dok", 64'(dresp_data_ok), 64'(dok));
    chk("rnd_irdata", 64'(iresp_data), iok ? 64'(bus_rdata[31:0]) : 64'd0);
    chk("rnd_drdata", dresp_data, dok ? bus_rdata : 64'd0);
  endtask

  task automatic model_advance();
    if (!reset) begin
      model_reset();
    end else if (m_owner == 0) begin
      if (dreq_valid && (!ireq_valid || m_run < MAXS)) begin
        m_owner = 2;
        m_run   = ireq_valid ? m_run + 1 : 0;
        m_addr  = dreq_addr;
        m_size  = dreq_size;
        m_strobe = dreq_strobe;
        m_data  = dreq_data;
      end else if (ireq_valid) begin
        m_owner  = 1;
        m_run    = 0;
        m_addr   = ireq_addr;
        m_size   = 3'd2;
        m_strobe = 8'd0;
        m_data   = 64'd0;
      end
    end else if (bus_ready) begin
      m_owner = 0;
    end
  endtask

  initial begin
    int got;
    vecs[0] = '{1'b1, 1'b0, 64'h8000_0000, 64'h0, 3'd0, 8'h00, 64'h0, 64'h0000_0000_0010_0093,
                2'b01, 64'h8000_0000, 3'd2, 8'h00, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0010_0093, 64'h0};
    vecs[1] = '{1'b0, 1'b1, 64'h1000, 64'h100, 3'd3, 8'h00, 64'hdead, 64'h1122_3344_5566_7788,
                2'b10, 64'h100, 3'd3, 8'h00, 64'hdead, 1'b0, 1'b0, 1'b1, 32'h0, 64'h1122_3344_5566_7788};
    vecs[2] = '{1'b1, 1'b1, 64'h4, 64'h8000_1000, 3'd3, 8'hFF, 64'h1234, 64'habc,
                2'b10, 64'h8000_1000, 3'd3, 8'hFF, 64'h1234, 1'b1, 1'b0, 1'b1, 32'h0, 64'habc};
    vecs[3] = '{1'b0, 1'b1, 64'h0, 64'h7, 3'd0, 8'h01, 64'hff, 64'hffff_ffff_ffff_ffff,
                2'b10, 64'h7, 3'd0, 8'h01, 64'hff, 1'b1, 1'b0, 1'b1, 32'h0, 64'hffff_ffff_ffff_ffff};
    vecs[4] = '{1'b1, 1'b0, 64'h1234_5678_9abc, 64'h0, 3'd0, 8'h00, 64'h0, 64'hcafe_babe_dead_beef,
                2'b01, 64'h1234_5678_9abc, 3'd2, 8'h00, 64'h0, 1'b0, 1'b1, 1'b0, 32'hdead_beef, 64'h0};
    vecs[5] = '{1'b0, 1'b0, 64'h0, 64'h0, 3'd0, 8'h00, 64'h0, 64'h5a5a,
                2'b00, 64'h0, 3'd0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0};

    // Reset state, with requests and a ready present.
    idle_inputs();
    reset = 1'b0;
    ireq_valid = 1'b1;
    ireq_addr = 64'h40;
    bus_ready = 1'b1;
    bus_rdata = 64'h77;
    #1;
    step();
    step();
    #2;
    chk("reset_bus_valid", 64'(bus_valid), 64'd0);
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_addr", bus_addr, 64'd0);
    chk("reset_iok", 64'(iresp_data_ok), 64'd0);
    chk("reset_irdata", 64'(iresp_data), 64'd0);
    reset = 1'b1;
    idle_inputs();
    step();

    // Vector table: request from IDLE, complete in the first grant cycle.
    for (int i = 0; i < 6; i++) begin
      ireq_valid  = vecs[i].iv;
      ireq_addr   = vecs[i].iaddr;
      dreq_valid  = vecs[i].dv;
      dreq_addr   = vecs[i].daddr;
      dreq_size   = vecs[i].dsize;
      dreq_strobe = vecs[i].dstrobe;
      dreq_data   = vecs[i].ddata;
      bus_ready   = 1'b1;
      bus_rdata   = vecs[i].rdata;
      #2;
      chk("vec_idle_iok", 64'(iresp_data_ok), 64'd0);
      chk("vec_idle_dok", 64'(dresp_data_ok), 64'd0);
      step();
      ireq_valid  = 1'b0;
      dreq_valid  = 1'b0;
      ireq_addr   = ~vecs[i].iaddr;
      dreq_addr   = ~vecs[i].daddr;
      dreq_data   = ~vecs[i].ddata;
      dreq_strobe = ~vecs[i].dstrobe;
      #2;
      chk("vec_grant", 64'(grant), 64'(vecs[i].e_grant));
      chk("vec_bus_valid", 64'(bus_valid), 64'(vecs[i].e_grant != 2'b00));
      chk("vec_addr", bus_addr, vecs[i].e_addr);
      chk("vec_size", 64'(bus_size), 64'(vecs[i].e_size));
      chk("vec_strobe", 64'(bus_strobe), 64'(vecs[i].e_strobe));
      chk("vec_wdata", bus_data, vecs[i].e_data);
      chk("vec_is_write", 64'(bus_is_write), 64'(vecs[i].e_write));
      chk("vec_iok", 64'(iresp_data_ok), 64'(vecs[i].e_iok));
      chk("vec_dok", 64'(dresp_data_ok), 64'(vecs[i].e_dok));
      chk("vec_irdata", 64'(iresp_data), 64'(vecs[i].e_irdata));
      chk("vec_drdata", dresp_data, vecs[i].e_drdata);
      step();
      #2;
      chk("vec_bubble_grant", 64'(grant), 64'd0);
      idle_inputs();
      step();
    end

    // Tie: data first, one IDLE bubble, then the waiting fetch.
    apply_reset();
    idle_inputs();
    ireq_valid = 1'b1;
    ireq_addr = 64'h40;
    dreq_valid = 1'b1;
    dreq_addr = 64'h8000_1000;
    dreq_size = 3'd3;
    dreq_strobe = 8'hFF;
    dreq_data = 64'h1234;
    step();
    #2;
    chk("tie_grant_d", 64'(grant), 64'd2);
    chk("tie_is_write", 64'(bus_is_write), 64'd1);
    chk("tie_wdata", bus_data, 64'h1234);
    chk("tie_dok_stalled", 64'(dresp_data_ok), 64'd0);
    bus_ready = 1'b1;
    #1;
    chk("tie_dok", 64'(dresp_data_ok), 64'd1);
    step();
    dreq_valid = 1'b0;
    #2;
    chk("tie_bubble", 64'(grant), 64'd0);
    chk("tie_bubble_iok", 64'(iresp_data_ok), 64'd0);
    step();
    #2;
    chk("tie_grant_i", 64'(grant), 64'd1);
    chk("tie_iaddr", bus_addr, 64'h40);
    chk("tie_iok", 64'(iresp_data_ok), 64'd1);

    // Starvation guard: both requesters saturate the bus.
    apply_reset();
    idle_inputs();
    ireq_valid = 1'b1;
    dreq_valid = 1'b1;
    bus_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      #2;
      if (grant != 2'b00) begin
        chk("starve_seq", 64'(grant), ((got % (MAXS + 1)) == MAXS) ? 64'd1 : 64'd2);
        got++;
      end
      step();
    end
    chk("starve_count", 64'(got), 64'd10);

    // Stall: latched fields must not follow the requester.
    apply_reset();
    idle_inputs();
    dreq_valid = 1'b1;
    dreq_addr = 64'h100;
    dreq_size = 3'd3;
    step();
    dreq_addr = 64'h200;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("stall_addr", bus_addr, 64'h100);
      chk("stall_dok", 64'(dresp_data_ok), 64'd0);
      step();
    end
    bus_ready = 1'b1;
    bus_rdata = 64'h55;
    #2;
    chk("stall_release_dok", 64'(dresp_data_ok), 64'd1);
    chk("stall_release_data", dresp_data, 64'h55);
    chk("stall_release_addr", bus_addr, 64'h100);
    step();
    #2;
    chk("stall_after_dok", 64'(dresp_data_ok), 64'd0);
    chk("stall_after_grant", 64'(grant), 64'd0);

    // Reset mid-transaction with the streak at its limit.
    apply_reset();
    idle_inputs();
    ireq_valid = 1'b1;
    dreq_valid = 1'b1;
    bus_ready = 1'b1;
    for (int k = 0; k < 7; k++) step();
    bus_ready = 1'b0;
    #2;
    chk("midrst_pre_grant", 64'(grant), 64'd2);
    reset = 1'b0;
    step();
    reset = 1'b1;
    #2;
    chk("midrst_bus_valid", 64'(bus_valid), 64'd0);
    chk("midrst_grant", 64'(grant), 64'd0);
    step();
    #2;
    chk("midrst_streak_cleared", 64'(grant), 64'd2);
    bus_ready = 1'b1;
    dreq_valid = 1'b0;
    ireq_addr = 64'h9000;
    step();
    step();
    #2;
    chk("midrst_fetch_grant", 64'(grant), 64'd1);
    chk("midrst_fetch_addr", bus_addr, 64'h9000);
    chk("midrst_fetch_iok", 64'(iresp_data_ok), 64'd1);

    // Randomized traffic against the reference model.
    apply_reset();
    idle_inputs();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 60) != 0);
      ireq_valid  = ($urandom_range(0, 2) != 0);
      ireq_addr   = {$urandom(), $urandom()};
      dreq_valid  = ($urandom_range(0, 2) != 0);
      dreq_addr   = {$urandom(), $urandom()};
      dreq_size   = 3'($urandom_range(0, 3));
      dreq_strobe = ($urandom_range(0, 1) != 0) ? 8'($urandom()) : 8'd0;
      dreq_data   = {$urandom(), $urandom()};
      bus_ready   = ($urandom_range(0, 2) == 0);
      bus_rdata   = {$urandom(), $urandom()};
      #2;
      model_check();
      model_advance();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
